// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Covers the clear/ready FSM encoding and the offsets used to slice packed port buses.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    localparam int ZERO_ADDR = 0;

    // LSB position of field idx in a bus of back-to-back w-bit fields
    function automatic int fld_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-entry pending bits for multi-cycle ops, with set/clear arbitration and read lookups.
// A new issue (set) beats a retiring write (clear) on the same entry.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  upd_en,
    input  logic                  ready,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic                  busy_set,
    input  logic [ADDR_W-1:0]     busy_addr,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD-1:0]        rd_pending
);

    logic [DEPTH-1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (upd_en) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p])
                    pend_d[wr_addr[fld_lsb(p, ADDR_W) +: ADDR_W]] = 1'b0;
            end
            if (busy_set && busy_addr != ADDR_W'(ZERO_ADDR))
                pend_d[busy_addr] = 1'b1;
        end
        pend_d[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) pend_q <= '0;
        else          pend_q <= pend_d;
    end

    for (genvar i = 0; i < NRD; i++) begin : gen_rd
        assign rd_pending[i] = ready & pend_q[rd_addr[fld_lsb(i, ADDR_W) +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: data array, write-to-read bypass and the
// post-reset clear sequence that zeroes every entry before init_done is raised.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_pending,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  busy_set,
    input  logic [ADDR_W-1:0]     busy_addr,
    output logic                  init_done
);

    rf_state_t         state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              init_done_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              ready;

    assign ready     = (state_q == READY);
    assign init_done = init_done_q;

    // Data array has no reset of its own; the CLEAR walk zeroes it instead.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    mem_q[cnt_q] <= '0;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end
                end
                READY: begin
                    if (run) begin
                        // Later ports overwrite earlier ones, so the highest port wins a conflict
                        for (int p = 0; p < NWR; p++) begin
                            if (wr_en[p] && wr_addr[fld_lsb(p, ADDR_W) +: ADDR_W] != ADDR_W'(ZERO_ADDR))
                                mem_q[wr_addr[fld_lsb(p, ADDR_W) +: ADDR_W]] <= wr_data[fld_lsb(p, DATA_W) +: DATA_W];
                        end
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : gen_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[fld_lsb(i, ADDR_W) +: ADDR_W];

        always_comb begin
            rv = mem_q[ra];
            if (BYPASS != 0 && run) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && wr_addr[fld_lsb(p, ADDR_W) +: ADDR_W] == ra)
                        rv = wr_data[fld_lsb(p, DATA_W) +: DATA_W];
                end
            end
            if (!ready || ra == ADDR_W'(ZERO_ADDR))
                rv = '0;
        end

        assign rd_data[fld_lsb(i, DATA_W) +: DATA_W] = rv;
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .NRD    (NRD),
        .NWR    (NWR)
    ) u_sb (
        .clk        (clk),
        .reset_n    (reset_n),
        .upd_en     (run & ready),
        .ready      (ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy_set   (busy_set),
        .busy_addr  (busy_addr),
        .rd_addr    (rd_addr),
        .rd_pending (rd_pending)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n, run, busy_set;
    logic [AW-1:0] ra0, ra1, wa0, wa1, busy_addr;
    logic [DW-1:0] wd0, wd1;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] rd_addr, wr_addr;
    logic [2*DW-1:0] wr_data, rd_data_b, rd_data_n;
    logic [1:0]    pend_b, pend_n;
    logic          done_b, done_n;
    logic [DW-1:0] b0, b1, n0, n1;

    int n_chk  = 0;
    int n_fail = 0;

    assign rd_addr = {ra1, ra0};
    assign wr_addr = {wa1, wa0};
    assign wr_data = {wd1, wd0};
    assign b0 = rd_data_b[DW-1:0];
    assign b1 = rd_data_b[2*DW-1:DW];
    assign n0 = rd_data_n[DW-1:0];
    assign n1 = rd_data_n[2*DW-1:DW];

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .run(run), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_pending(pend_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr), .init_done(done_b)
    );

    regfile_mp #(.BYPASS(0)) u_dut_n (
        .clk(clk), .reset_n(reset_n), .run(run), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_pending(pend_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr), .init_done(done_n)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 2'b00; busy_set = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; busy_addr = '0;
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b1; ra0 = '0; ra1 = '0;
        idle();
        tick(); tick();
        chk("rst_done_b", {31'b0, done_b}, 32'd0);
        chk("rst_done_n", {31'b0, done_n}, 32'd0);
        chk("rst_pend",   {30'b0, pend_b}, 32'd0);
        chk("rst_rd0",    b0, 32'd0);

        // Release reset with a write and busy_set that CLEAR must ignore
        reset_n = 1'b1;
        wr_en = 2'b01; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        busy_set = 1'b1; busy_addr = 5'd5; ra0 = 5'd5;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("clr_done_%0d", k), {31'b0, done_b}, (k >= 32) ? 32'd1 : 32'd0);
            if (k < 32) chk($sformatf("clr_rd_%0d", k), b0, 32'd0);
        end
        chk("clr_done_n", {31'b0, done_n}, 32'd1);
        idle();
        #1;
        chk("clr_r5_data", b0, 32'd0);
        chk("clr_r5_pend", {31'b0, pend_b[0]}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            ra0 = AW'(a); #1;
            chk($sformatf("clr_entry_%0d", a), b0, 32'd0);
        end

        // Bypass of a same-cycle write
        wr_en = 2'b01; wa0 = 5'd3; wd0 = 32'h12345678; ra1 = 5'd3; #1;
        chk("byp_same_b", b1, 32'h12345678);
        chk("byp_same_n", n1, 32'd0);
        tick(); idle(); #1;
        chk("byp_next_b", b1, 32'h12345678);
        chk("byp_next_n", n1, 32'h12345678);

        // Write conflict: the higher port wins
        wr_en = 2'b11; wa0 = 5'd7; wd0 = 32'hAAAA0000; wa1 = 5'd7; wd1 = 32'h5555FFFF; ra0 = 5'd7; #1;
        chk("conf_byp_b", b0, 32'h5555FFFF);
        chk("conf_byp_n", n0, 32'd0);
        tick(); idle(); #1;
        chk("conf_r7_b", b0, 32'h5555FFFF);
        chk("conf_r7_n", n0, 32'h5555FFFF);

        // Scoreboard set, clear, and set-beats-clear
        busy_set = 1'b1; busy_addr = 5'd9; ra0 = 5'd9; #1;
        chk("sb_set_same", {31'b0, pend_b[0]}, 32'd0);
        tick(); idle(); #1;
        chk("sb_set_next", {31'b0, pend_b[0]}, 32'd1);
        wr_en = 2'b01; wa0 = 5'd9; wd0 = 32'h00000099; #1;
        chk("sb_clr_same", {31'b0, pend_b[0]}, 32'd1);
        tick(); idle(); #1;
        chk("sb_clr_next", {31'b0, pend_b[0]}, 32'd0);
        chk("sb_r9_data",  b0, 32'h00000099);
        wr_en = 2'b10; wa1 = 5'd9; wd1 = 32'h00000100; busy_set = 1'b1; busy_addr = 5'd9;
        tick(); idle(); #1;
        chk("sb_setwin",   {31'b0, pend_b[0]}, 32'd1);
        chk("sb_setwin_d", b0, 32'h00000100);
        chk("sb_setwin_n", {31'b0, pend_n[0]}, 32'd1);

        // run=0 holds contents and scoreboard
        wr_en = 2'b01; wa0 = 5'd4; wd0 = 32'h00000044;
        tick(); idle();
        run = 1'b0; wr_en = 2'b10; wa1 = 5'd4; wd1 = 32'h00000BAD;
        busy_set = 1'b1; busy_addr = 5'd4; ra0 = 5'd4; #1;
        chk("hold_same_b", b0, 32'h00000044);
        tick(); idle(); #1;
        chk("hold_r4",     b0, 32'h00000044);
        chk("hold_pend4",  {31'b0, pend_b[0]}, 32'd0);
        run = 1'b1;

        // Entry 0 is hardwired
        wr_en = 2'b11; wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'hFFFFFFFF; wd1 = 32'h13572468;
        busy_set = 1'b1; busy_addr = 5'd0; ra0 = 5'd0; #1;
        chk("r0_same", b0, 32'd0);
        tick(); idle(); #1;
        chk("r0_data", b0, 32'd0);
        chk("r0_pend", {31'b0, pend_b[0]}, 32'd0);

        // Reset in the middle of CLEAR restarts the full walk
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        chk("mid_done", {31'b0, done_b}, 32'd0);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k >= 31) chk($sformatf("re_done_%0d", k), {31'b0, done_b}, (k == 32) ? 32'd1 : 32'd0);
        end
        ra0 = 5'd3; ra1 = 5'd7; #1;
        chk("re_r3", b0, 32'd0);
        chk("re_r7", b1, 32'd0);
        ra0 = 5'd9; ra1 = 5'd4; #1;
        chk("re_r9",    b0, 32'd0);
        chk("re_r4",    b1, 32'd0);
        chk("re_pend9", {31'b0, pend_b[0]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
